// File: rtl/rr_mux4_if.sv
// rtl/rr_mux4_if.sv - four input channels and one tagged output stream of rr_mux4
interface rr_mux4_if #(
   parameter int WIDTH = 8
);
   logic [WIDTH-1:0] d0;
   logic [WIDTH-1:0] d1;
   logic [WIDTH-1:0] d2;
   logic [WIDTH-1:0] d3;
   logic             v0;
   logic             v1;
   logic             v2;
   logic             v3;
   logic             r0;
   logic             r1;
   logic             r2;
   logic             r3;
   logic [WIDTH-1:0] z;
   logic             zv;
   logic             zr;
   logic             s1;
   logic             s0;

   // master: the channel sources plus the output consumer
   modport master (
      output d0, d1, d2, d3, v0, v1, v2, v3, zr,
      input  r0, r1, r2, r3, z, zv, s1, s0
   );

   // slave: the multiplexer itself
   modport slave (
      input  d0, d1, d2, d3, v0, v1, v2, v3, zr,
      output r0, r1, r2, r3, z, zv, s1, s0
   );
endinterface

// File: rtl/rr_mux4.sv
// rtl/rr_mux4.sv - 4:1 round-robin merge into one registered stream tagged with source index
module rr_mux4 #(
   parameter int WIDTH = 8
) (
   input  logic     clk,
   input  logic     rst_n,
   rr_mux4_if.slave bus
);
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } state_t;

   state_t           state_q;
   state_t           state_d;
   logic [WIDTH-1:0] z_q;
   logic [WIDTH-1:0] z_d;
   logic [1:0]       src_q;
   logic [1:0]       src_d;
   logic [1:0]       last_q;
   logic [1:0]       last_d;

   logic [3:0]       v_vec;
   logic [3:0]       gnt;
   logic [3:0]       r_vec;
   logic [1:0]       sel;
   logic [1:0]       idx;
   logic             found;
   logic             accept_en;
   logic             xfer;
   logic [WIDTH-1:0] d_sel;

   assign v_vec = {bus.v3, bus.v2, bus.v1, bus.v0};

   // Search starts just after the last winner and ends on it, so a lone requester still wins.
   always_comb begin
      gnt   = '0;
      sel   = last_q;
      idx   = '0;
      found = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         idx = last_q + 2'(k);
         if (!found && v_vec[idx]) begin
            gnt[idx] = 1'b1;
            sel      = idx;
            found    = 1'b1;
         end
      end
   end

   // zr only opens the input side; it never reaches zv within the same cycle.
   assign accept_en = (state_q == EMPTY) || bus.zr;
   assign r_vec     = (rst_n && accept_en) ? gnt : 4'b0000;
   assign xfer      = |r_vec;

   always_comb begin
      d_sel = bus.d0;
      case (sel)
         2'd0:    d_sel = bus.d0;
         2'd1:    d_sel = bus.d1;
         2'd2:    d_sel = bus.d2;
         default: d_sel = bus.d3;
      endcase
   end

   always_comb begin
      z_d     = z_q;
      src_d   = src_q;
      last_d  = last_q;
      state_d = state_q;
      if (xfer) begin
         z_d     = d_sel;
         src_d   = sel;
         last_d  = sel;
         state_d = FULL;
      end else if (bus.zr) begin
         state_d = EMPTY;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         z_q     <= '0;
         src_q   <= 2'd0;
         last_q  <= 2'd3;
      end else begin
         state_q <= state_d;
         z_q     <= z_d;
         src_q   <= src_d;
         last_q  <= last_d;
      end
   end

   assign bus.r0 = r_vec[0];
   assign bus.r1 = r_vec[1];
   assign bus.r2 = r_vec[2];
   assign bus.r3 = r_vec[3];
   assign bus.z  = z_q;
   assign bus.zv = (state_q == FULL);
   assign bus.s1 = src_q[1];
   assign bus.s0 = src_q[0];
endmodule

// File: tb/tb_rr_mux4.sv
// tb/tb_rr_mux4.sv - directed self-checking bench for rr_mux4
module tb_rr_mux4;
   localparam int WIDTH = 8;

   logic clk;
   logic rst_n;
   int   errors;
   int   checks;

   rr_mux4_if #(.WIDTH(WIDTH)) bus ();

   rr_mux4 #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_v(input logic [3:0] m);
      bus.v0 = m[0];
      bus.v1 = m[1];
      bus.v2 = m[2];
      bus.v3 = m[3];
   endtask

   task automatic set_d(input int ch, input logic [WIDTH-1:0] val);
      case (ch)
         0:       bus.d0 = val;
         1:       bus.d1 = val;
         2:       bus.d2 = val;
         default: bus.d3 = val;
      endcase
   endtask

   function automatic logic [3:0] r_now();
      return {bus.r3, bus.r2, bus.r1, bus.r0};
   endfunction

   function automatic logic [1:0] s_now();
      return {bus.s1, bus.s0};
   endfunction

   // downstream dmux4 model: zv routed to output z<s1s0>
   function automatic logic [3:0] dmux_out();
      logic [3:0] one;
      one = 4'b0001;
      return bus.zv ? (one << {bus.s1, bus.s0}) : 4'b0000;
   endfunction

   initial begin
      logic [1:0]       exp_s;
      logic [WIDTH-1:0] exp_z;
      errors = 0;
      checks = 0;
      rst_n  = 1'b0;
      bus.zr = 1'b1;
      set_v(4'hF);
      for (int c = 0; c < 4; c++) set_d(c, 8'hA0 + 8'(c));

      repeat (2) @(negedge clk);
      #1;
      check_eq("rst_zv", 32'(bus.zv), 32'd0);
      check_eq("rst_z", 32'(bus.z), 32'd0);
      check_eq("rst_s", 32'(s_now()), 32'd0);
      check_eq("rst_r", 32'(r_now()), 32'd0);

      // round robin over all four channels
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_eq("rr_first_grant", 32'(r_now()), 32'b0001);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check_eq("rr_z", 32'(bus.z), 32'(8'hA0 + 8'(i % 4)));
         check_eq("rr_s", 32'(s_now()), 32'(i % 4));
         check_eq("rr_zv", 32'(bus.zv), 32'd1);
      end
      set_v(4'h0);
      @(negedge clk);
      check_eq("drain_zv", 32'(bus.zv), 32'd0);
      check_eq("drain_z_stale", 32'(bus.z), 32'hA0);
      check_eq("drain_s_stale", 32'(s_now()), 32'd0);

      // backpressure with a competing request during the stall
      set_d(2, 8'h5C);
      set_v(4'b0100);
      bus.zr = 1'b0;
      #1;
      check_eq("bp_r_empty", 32'(r_now()), 32'b0100);
      @(negedge clk);
      check_eq("bp_cap_z", 32'(bus.z), 32'h5C);
      set_d(0, 8'h11);
      set_v(4'b0001);
      for (int i = 0; i < 3; i++) begin
         #1;
         check_eq("bp_hold_r", 32'(r_now()), 32'd0);
         check_eq("bp_hold_z", 32'(bus.z), 32'h5C);
         check_eq("bp_hold_s", 32'(s_now()), 32'd2);
         check_eq("bp_hold_zv", 32'(bus.zv), 32'd1);
         @(negedge clk);
      end
      bus.zr = 1'b1;
      #1;
      check_eq("bp_release_r", 32'(r_now()), 32'b0001);
      @(negedge clk);
      check_eq("b2b_z", 32'(bus.z), 32'h11);
      check_eq("b2b_s", 32'(s_now()), 32'd0);
      check_eq("b2b_zv", 32'(bus.zv), 32'd1);
      set_v(4'h0);
      @(negedge clk);
      check_eq("bp_done_zv", 32'(bus.zv), 32'd0);

      // fairness skip: channels 1 and 3 only
      set_d(1, 8'hB1);
      set_d(3, 8'hB3);
      set_v(4'b1010);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         exp_s = (i % 2 == 0) ? 2'd1 : 2'd3;
         exp_z = (i % 2 == 0) ? 8'hB1 : 8'hB3;
         check_eq("skip_z", 32'(bus.z), 32'(exp_z));
         check_eq("skip_s", 32'(s_now()), 32'(exp_s));
      end
      set_v(4'h0);
      @(negedge clk);
      check_eq("skip_done_zv", 32'(bus.zv), 32'd0);

      // lone channel granted every cycle
      set_d(2, 8'h20);
      set_v(4'b0100);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_eq("solo_z", 32'(bus.z), 32'(8'h20 + 8'(i)));
         check_eq("solo_s", 32'(s_now()), 32'd2);
         check_eq("solo_zv", 32'(bus.zv), 32'd1);
         set_d(2, 8'h21 + 8'(i));
      end
      set_v(4'h0);
      @(negedge clk);
      check_eq("solo_done_zv", 32'(bus.zv), 32'd0);

      // loop-back through a dmux4 model
      for (int k = 0; k < 4; k++) begin
         set_d(k, 8'h40 + 8'(k));
         set_v(4'(1 << k));
         @(negedge clk);
         check_eq("loop_dmux", 32'(dmux_out()), 32'(1 << k));
         check_eq("loop_z", 32'(bus.z), 32'(8'h40 + 8'(k)));
         set_v(4'h0);
         @(negedge clk);
         check_eq("loop_idle", 32'(dmux_out()), 32'd0);
      end

      // asynchronous reset while holding a stalled word
      set_d(1, 8'h77);
      set_v(4'b0010);
      bus.zr = 1'b0;
      @(negedge clk);
      check_eq("mid_pre_zv", 32'(bus.zv), 32'd1);
      check_eq("mid_pre_s", 32'(s_now()), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_zv", 32'(bus.zv), 32'd0);
      check_eq("mid_rst_z", 32'(bus.z), 32'd0);
      check_eq("mid_rst_s", 32'(s_now()), 32'd0);
      @(negedge clk);
      set_d(0, 8'hA0);
      set_v(4'hF);
      bus.zr = 1'b1;
      rst_n  = 1'b1;
      #1;
      check_eq("mid_first_r", 32'(r_now()), 32'b0001);
      @(negedge clk);
      check_eq("mid_first_z", 32'(bus.z), 32'hA0);
      check_eq("mid_first_s", 32'(s_now()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
